// File: rtl/arm7tdmi_mmu_arbiter_if.sv
// CPU-side bus bundle between the I/D requesters, the arbiter and the MMU cpu_* port.
// The slave modport is the arbiter's view; master is the requesters'/MMU's view.
interface arm7tdmi_mmu_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_vaddr;
   logic [31:0]           i_rdata;
   logic                  i_ready;
   logic                  i_abort;

   logic                  d_req;
   logic                  d_write;
   logic [1:0]            d_size;
   logic [ADDR_WIDTH-1:0] d_vaddr;
   logic [31:0]           d_wdata;
   logic [31:0]           d_rdata;
   logic                  d_ready;
   logic                  d_abort;

   logic                  m_req;
   logic                  m_write;
   logic [1:0]            m_size;
   logic [ADDR_WIDTH-1:0] m_vaddr;
   logic [31:0]           m_wdata;
   logic [31:0]           m_rdata;
   logic                  m_ready;
   logic                  m_abort;

   modport slave (
      input  i_req, i_vaddr,
      output i_rdata, i_ready, i_abort,
      input  d_req, d_write, d_size, d_vaddr, d_wdata,
      output d_rdata, d_ready, d_abort,
      output m_req, m_write, m_size, m_vaddr, m_wdata,
      input  m_rdata, m_ready, m_abort
   );

   modport master (
      output i_req, i_vaddr,
      input  i_rdata, i_ready, i_abort,
      output d_req, d_write, d_size, d_vaddr, d_wdata,
      input  d_rdata, d_ready, d_abort,
      input  m_req, m_write, m_size, m_vaddr, m_wdata,
      output m_rdata, m_ready, m_abort
   );
endinterface

// File: rtl/arm7tdmi_mmu_arbiter.sv
// Shares the MMU CPU port between I-fetch and data requesters and sequences TLB flush-all.
// Optional macro ARB_STATS_EN adds grant/abort statistics counters.
module arm7tdmi_mmu_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   arm7tdmi_mmu_arbiter_if.slave       bus,
   input  logic                        flush_req,
   output logic                        flush_ack,
   output logic                        tlb_flush_all,
   output logic                        arb_busy
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]                 stat_i_grants,
   output logic [31:0]                 stat_d_grants,
   output logic [31:0]                 stat_aborts
`endif
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GRANT_I = 2'd1;
   localparam logic [1:0] GRANT_D = 2'd2;
   localparam logic [1:0] FLUSH   = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;
   logic             grant_i;
   logic             grant_d;
   logic             done;

   assign grant_i = (state == GRANT_I);
   assign grant_d = (state == GRANT_D);
   assign done    = bus.m_ready | bus.m_abort;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (flush_req)
               state_nxt = FLUSH;
            else if (bus.i_req && (starve_cnt == STARVE_MAX))
               state_nxt = GRANT_I;
            else if (bus.d_req)
               state_nxt = GRANT_D;
            else if (bus.i_req)
               state_nxt = GRANT_I;
         end
         GRANT_I, GRANT_D: begin
            if (done)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counter only moves on the IDLE->GRANT decision; a flush leaves it untouched.
   always_comb begin
      starve_nxt = starve_cnt;
      if ((state == IDLE) && ((state_nxt == GRANT_I) || (state_nxt == GRANT_D))) begin
         if ((state_nxt == GRANT_D) && bus.i_req)
            starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
         else
            starve_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   assign bus.m_req   = grant_i | grant_d;
   assign bus.m_write = grant_d & bus.d_write;
   assign bus.m_size  = grant_i ? 2'b10 : (grant_d ? bus.d_size : 2'b00);
   assign bus.m_vaddr = grant_i ? bus.i_vaddr : (grant_d ? bus.d_vaddr : '0);
   assign bus.m_wdata = grant_d ? bus.d_wdata : '0;

   assign bus.i_ready = grant_i & bus.m_ready & ~bus.m_abort;
   assign bus.i_abort = grant_i & bus.m_abort;
   assign bus.i_rdata = (grant_i & done) ? bus.m_rdata : '0;

   assign bus.d_ready = grant_d & bus.m_ready & ~bus.m_abort;
   assign bus.d_abort = grant_d & bus.m_abort;
   assign bus.d_rdata = (grant_d & done) ? bus.m_rdata : '0;

   assign tlb_flush_all = (state == FLUSH);
   assign flush_ack     = (state == FLUSH);
   assign arb_busy      = (state != IDLE);

`ifdef ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_i_grants <= '0;
         stat_d_grants <= '0;
         stat_aborts   <= '0;
      end else begin
         if ((state == IDLE) && (state_nxt == GRANT_I))
            stat_i_grants <= stat_i_grants + 32'd1;
         if ((state == IDLE) && (state_nxt == GRANT_D))
            stat_d_grants <= stat_d_grants + 32'd1;
         if ((grant_i | grant_d) && bus.m_abort)
            stat_aborts <= stat_aborts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arm7tdmi_mmu_arbiter.sv
// Directed bench for arm7tdmi_mmu_arbiter (STARVE_LIMIT=4); build with ARB_STATS_EN to cover the counters.
module tb_arm7tdmi_mmu_arbiter;

   logic clk;
   logic rst_n;
   logic flush_req;
   logic flush_ack;
   logic tlb_flush_all;
   logic arb_busy;
`ifdef ARB_STATS_EN
   logic [31:0] stat_i_grants;
   logic [31:0] stat_d_grants;
   logic [31:0] stat_aborts;
`endif

   int passes = 0;
   int total  = 0;
   int fails  = 0;
   int flush_pulses = 0;
   int pulses_before;

   arm7tdmi_mmu_arbiter_if #(.ADDR_WIDTH(32)) bus ();

   arm7tdmi_mmu_arbiter #(
      .ADDR_WIDTH   (32),
      .STARVE_LIMIT (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .flush_req     (flush_req),
      .flush_ack     (flush_ack),
      .tlb_flush_all (tlb_flush_all),
      .arb_busy      (arb_busy)
`ifdef ARB_STATS_EN
      ,
      .stat_i_grants (stat_i_grants),
      .stat_d_grants (stat_d_grants),
      .stat_aborts   (stat_aborts)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (tlb_flush_all)
         flush_pulses++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      flush_req = 1'b0;
      bus.i_req = 1'b0;   bus.i_vaddr = '0;
      bus.d_req = 1'b0;   bus.d_write = 1'b0; bus.d_size = 2'b00;
      bus.d_vaddr = '0;   bus.d_wdata = '0;
      bus.m_rdata = '0;   bus.m_ready = 1'b0; bus.m_abort = 1'b0;

      // reset state
      tick(); tick();
      check("rst_m_req", 64'(bus.m_req), 64'd0);
      check("rst_busy", 64'(arb_busy), 64'd0);
      check("rst_flush", 64'(tlb_flush_all), 64'd0);
      check("rst_starve", 64'(dut.starve_cnt), 64'd0);
      rst_n = 1'b1;

      // MMU responses in IDLE are ignored
      bus.m_ready = 1'b1; bus.m_abort = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
      #1;
      check("idle_i_ready", 64'(bus.i_ready), 64'd0);
      check("idle_d_abort", 64'(bus.d_abort), 64'd0);
      check("idle_d_rdata", 64'(bus.d_rdata), 64'd0);
      tick();
      check("idle_busy", 64'(arb_busy), 64'd0);
      bus.m_ready = 1'b0; bus.m_abort = 1'b0; bus.m_rdata = '0;

      // 1: single instruction fetch, MMU ready 2 cycles after m_req
      bus.i_req = 1'b1; bus.i_vaddr = 32'h0000_1000;
      #1;
      check("t1_m_req_same", 64'(bus.m_req), 64'd0);
      tick();
      check("t1_m_req", 64'(bus.m_req), 64'd1);
      check("t1_m_vaddr", 64'(bus.m_vaddr), 64'h1000);
      check("t1_m_write", 64'(bus.m_write), 64'd0);
      check("t1_m_size", 64'(bus.m_size), 64'd2);
      check("t1_busy", 64'(arb_busy), 64'd1);
      tick();
      check("t1_i_ready_early", 64'(bus.i_ready), 64'd0);
      tick();
      bus.m_ready = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
      #1;
      check("t1_i_ready", 64'(bus.i_ready), 64'd1);
      check("t1_i_rdata", 64'(bus.i_rdata), 64'hDEAD_BEEF);
      check("t1_d_ready", 64'(bus.d_ready), 64'd0);
      tick();
      bus.m_ready = 1'b0; bus.m_rdata = '0; bus.i_req = 1'b0;
      #1;
      check("t1_i_ready_pulse", 64'(bus.i_ready), 64'd0);
      check("t1_idle_m_req", 64'(bus.m_req), 64'd0);

      // 2: simultaneous I and D, D wins, then mandatory IDLE, then I
      bus.i_req = 1'b1; bus.i_vaddr = 32'h0000_1000;
      bus.d_req = 1'b1; bus.d_write = 1'b1; bus.d_size = 2'b10;
      bus.d_vaddr = 32'h0000_2000; bus.d_wdata = 32'hCAFE_F00D;
      tick();
      check("t2_d_vaddr", 64'(bus.m_vaddr), 64'h2000);
      check("t2_d_write", 64'(bus.m_write), 64'd1);
      check("t2_d_wdata", 64'(bus.m_wdata), 64'hCAFE_F00D);
      bus.m_ready = 1'b1;
      #1;
      check("t2_d_ready", 64'(bus.d_ready), 64'd1);
      check("t2_i_ready_not", 64'(bus.i_ready), 64'd0);
      tick();
      bus.m_ready = 1'b0; bus.d_req = 1'b0; bus.d_write = 1'b0;
      #1;
      check("t2_gap_m_req", 64'(bus.m_req), 64'd0);
      check("t2_gap_busy", 64'(arb_busy), 64'd0);
      tick();
      check("t2_i_vaddr", 64'(bus.m_vaddr), 64'h1000);
      check("t2_i_write", 64'(bus.m_write), 64'd0);
      check("t2_i_wdata", 64'(bus.m_wdata), 64'd0);
      bus.m_ready = 1'b1; bus.m_rdata = 32'h1234_0000;
      #1;
      check("t2_i_ready", 64'(bus.i_ready), 64'd1);
      check("t2_i_rdata", 64'(bus.i_rdata), 64'h1234_0000);
      tick();
      bus.m_ready = 1'b0; bus.m_rdata = '0; bus.i_req = 1'b0;

      // 3: starvation guard, D,D,D,D then forced I
      bus.d_req = 1'b1; bus.d_write = 1'b0; bus.d_size = 2'b01; bus.d_vaddr = 32'h0000_2000;
      bus.i_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("t3_d%0d_vaddr", k), 64'(bus.m_vaddr), 64'h2000);
         check($sformatf("t3_d%0d_size", k), 64'(bus.m_size), 64'd1);
         bus.m_ready = 1'b1;
         tick();
         bus.m_ready = 1'b0;
      end
      check("t3_starve_max", 64'(dut.starve_cnt), 64'd4);
      tick();
      check("t3_forced_i", 64'(bus.m_vaddr), 64'h1000);
      check("t3_forced_size", 64'(bus.m_size), 64'd2);
      check("t3_starve_clr", 64'(dut.starve_cnt), 64'd0);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      tick();
      check("t3_after_i_d", 64'(bus.m_vaddr), 64'h2000);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0; bus.d_req = 1'b0; bus.i_req = 1'b0;

      // 4: flush raised during GRANT_D with I pending
      pulses_before = flush_pulses;
      bus.d_req = 1'b1; bus.i_req = 1'b1;
      tick();
      check("t4_grant_d", 64'(bus.m_vaddr), 64'h2000);
      flush_req = 1'b1;
      tick();
      check("t4_no_flush_mid", 64'(tlb_flush_all), 64'd0);
      bus.m_ready = 1'b1;
      #1;
      check("t4_d_ready", 64'(bus.d_ready), 64'd1);
      tick();
      bus.m_ready = 1'b0; bus.d_req = 1'b0;
      #1;
      check("t4_idle_flush", 64'(tlb_flush_all), 64'd0);
      check("t4_idle_m_req", 64'(bus.m_req), 64'd0);
      tick();
      check("t4_flush", 64'(tlb_flush_all), 64'd1);
      check("t4_ack", 64'(flush_ack), 64'd1);
      check("t4_flush_m_req", 64'(bus.m_req), 64'd0);
      flush_req = 1'b0;
      tick();
      check("t4_flush_end", 64'(tlb_flush_all), 64'd0);
      check("t4_post_idle", 64'(bus.m_req), 64'd0);
      tick();
      check("t4_grant_i", 64'(bus.m_vaddr), 64'h1000);
      check("t4_one_pulse", 64'(flush_pulses - pulses_before), 64'd1);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0; bus.i_req = 1'b0;

      // 5: ready and abort together, abort wins
      bus.d_req = 1'b1;
      tick();
      bus.m_ready = 1'b1; bus.m_abort = 1'b1; bus.m_rdata = 32'h1234_5678;
      #1;
      check("t5_d_abort", 64'(bus.d_abort), 64'd1);
      check("t5_d_ready", 64'(bus.d_ready), 64'd0);
      check("t5_d_rdata", 64'(bus.d_rdata), 64'h1234_5678);
      check("t5_i_abort", 64'(bus.i_abort), 64'd0);
      tick();
      bus.m_ready = 1'b0; bus.m_abort = 1'b0; bus.m_rdata = '0; bus.d_req = 1'b0;
      #1;
      check("t5_idle", 64'(arb_busy), 64'd0);
`ifdef ARB_STATS_EN
      check("t5_stat_aborts", 64'(stat_aborts), 64'd1);
`endif

      // 6: reset mid GRANT_D abandons the transaction
      bus.d_req = 1'b1;
      tick();
      check("t6_grant_d", 64'(bus.m_req), 64'd1);
      rst_n = 1'b0; bus.m_ready = 1'b1;
      #1;
      check("t6_rst_m_req", 64'(bus.m_req), 64'd0);
      check("t6_rst_d_ready", 64'(bus.d_ready), 64'd0);
      check("t6_rst_d_abort", 64'(bus.d_abort), 64'd0);
      check("t6_rst_busy", 64'(arb_busy), 64'd0);
      tick();
      check("t6_rst_hold", 64'(bus.d_ready), 64'd0);
      rst_n = 1'b1; bus.m_ready = 1'b0;
      tick();
      check("t6_regrant", 64'(bus.m_req), 64'd1);
      check("t6_regrant_vaddr", 64'(bus.m_vaddr), 64'h2000);
      bus.m_ready = 1'b1;
      #1;
      check("t6_d_ready", 64'(bus.d_ready), 64'd1);
      tick();
      bus.m_ready = 1'b0; bus.d_req = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/arm7tdmi_mmu_arbiter.md
Name: arm7tdmi_mmu_arbiter

Overview:
Shares the single CPU-side port of arm7tdmi_mmu between the instruction-fetch requester (read-only) and the data requester (read/write).
Also sequences TLB flush-all requests so a flush is issued only when no translation is in flight.
Sits between the core's I/D bus units and the MMU cpu_* interface.
Data has fixed priority, with a starvation guard that forces an instruction grant.

Parameters:
ADDR_WIDTH, 32, virtual address width
STARVE_LIMIT, 4, consecutive D grants allowed while i_req is pending before I is forced (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  instruction request, held until i_ready/i_abort
i_vaddr  in  ADDR_WIDTH  instruction virtual address
i_rdata  out  32  instruction read data
i_ready  out  1  instruction completion pulse
i_abort  out  1  instruction abort pulse
d_req  in  1  data request, held until d_ready/d_abort
d_write  in  1  data write
d_size  in  2  data size (00 byte, 01 half, 10 word)
d_vaddr  in  ADDR_WIDTH  data virtual address
d_wdata  in  32  data write data
d_rdata  out  32  data read data
d_ready  out  1  data completion pulse
d_abort  out  1  data abort pulse
m_req  out  1  to MMU cpu_req
m_write  out  1  to MMU cpu_write
m_size  out  2  to MMU cpu_size
m_vaddr  out  ADDR_WIDTH  to MMU cpu_vaddr
m_wdata  out  32  to MMU cpu_wdata
m_rdata  in  32  from MMU cpu_rdata
m_ready  in  1  from MMU cpu_ready
m_abort  in  1  from MMU cpu_abort
flush_req  in  1  TLB flush-all request (level), held until flush_ack
flush_ack  out  1  flush issued pulse
tlb_flush_all  out  1  to MMU tlb_flush_all, one-cycle pulse
arb_busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state IDLE, starve_cnt 0.
  - All outputs 0 asynchronously.
  - Reset mid-transaction abandons it: no ready/abort is issued.
- States: IDLE, GRANT_I, GRANT_D, FLUSH.
- IDLE priority, decided at the clock edge:
  1. flush_req → FLUSH
  2. i_req && starve_cnt == STARVE_LIMIT → GRANT_I
  3. d_req → GRANT_D
  4. i_req → GRANT_I
  5. otherwise stay in IDLE
- Latency: a request present in IDLE drives m_req high in the very next cycle.
- GRANT_x outputs:
  - m_req = 1; m_* are muxed combinationally from the granted port.
  - GRANT_I drives m_write = 0, m_size = 2'b10, m_wdata = 0.
  - The requester must hold its inputs stable while granted.
- Completion: the cycle m_ready or m_abort is high in GRANT_x:
  - x_ready = m_ready & ~m_abort.
  - x_abort = m_abort; abort wins if both are high.
  - x_rdata = m_rdata in that cycle, else 0.
  - Next state is IDLE.
  - The non-granted port never sees ready/abort.
- Requester rule: in the cycle after its ready/abort, a requester either deasserts req or presents a new request. The mandatory IDLE cycle guarantees no stale re-grant.
- m_* are 0 outside GRANT states. arb_busy = (state != IDLE).
- FLUSH:
  - tlb_flush_all = 1 and flush_ack = 1 for exactly one cycle, then IDLE.
  - A flush arriving mid-transaction waits for completion, then beats any pending I/D.
  - flush_req must deassert the cycle after flush_ack. If still high in IDLE, it is treated as a new flush.
- starve_cnt (width $clog2(STARVE_LIMIT+1)), updated when leaving IDLE:
  - GRANT_D with i_req high → saturating +1.
  - GRANT_I, or i_req low at the decision → 0.
  - FLUSH → unchanged.
- m_ready/m_abort in IDLE or FLUSH are ignored.

Optional Feature:
ARB_STATS_EN:
- When defined, adds output ports stat_i_grants, stat_d_grants, stat_aborts (32 bits each, reset 0, wrapping).
  - stat_i_grants increments on entry to GRANT_I.
  - stat_d_grants increments on entry to GRANT_D.
  - stat_aborts increments on any forwarded abort.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. i_req with i_vaddr=0x00001000; MMU m_ready 2 cycles after m_req, m_rdata=0xDEADBEEF → m_req rises 1 cycle after i_req, m_vaddr=0x00001000, m_write=0, m_size=10; i_ready single pulse with i_rdata=0xDEADBEEF; d_ready stays 0.
2. i_req (0x1000) and d_req (write, 0x2000, d_wdata=0xCAFEF00D) raised in the same cycle → D served first (m_write=1, m_wdata=0xCAFEF00D); after d_ready, one IDLE cycle, then I is served.
3. STARVE_LIMIT=4, d_req held continuously, i_req held → grants D,D,D,D,I; starve_cnt back to 0 after the I grant.
4. flush_req raised during GRANT_D with i_req pending → tlb_flush_all/flush_ack pulse in the cycle after d_ready's following IDLE, before GRANT_I; exactly one pulse.
5. GRANT_D with m_ready=1 and m_abort=1 in the same cycle → d_abort=1, d_ready=0, state returns to IDLE; with ARB_STATS_EN, stat_aborts=1.
6. rst_n low for 1 cycle during GRANT_D → m_req, d_ready, d_abort, arb_busy drop to 0 immediately; no completion is issued; a new d_req after reset is served normally.
